aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
Iterative AES-128 key schedule that feeds round keys to the round datapath.
- Accepts one 128-bit cipher key via a valid/ready handshake.
- Generates one round key per cycle into an internal 11-entry key store.
- Serves round keys through a registered read port, indexed by round number and job type (ENCRYPT forward order, DECRYPT reverse order).
- Sits beside the round pipeline: the round controller reads the key for each stage from this block.

Parameters:
NR, 10, number of AES rounds; only 10 (AES-128) is supported.
KW, 128, key and round-key width in bits.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
key_valid  in  1  new cipher key presented
key_ready  out  1  block can accept a key this cycle
key_in  in  KW  cipher key, byte 0 in bits [127:120]
keys_valid  out  1  all NR+1 round keys present and consistent
busy  out  1  expansion in progress
rd_en  in  1  round-key read request
rd_round  in  4  pipeline round index, 0..NR
rd_type  in  job_t  ENCRYPT / DECRYPT / INVALID
rd_valid  out  1  rd_key holds the response to the previous-cycle request
rd_key  out  KW  round key

Behaviour:
Reset (async, rst_n=0):
- FSM goes to IDLE; round counter is 0; key store is cleared to 0.
- Outputs: keys_valid=0, busy=0, rd_valid=0, rd_key=0.
- key_ready=1 as soon as reset deasserts.

FSM states and transitions:
- IDLE: key_ready=1. On key_valid, write rk[0]=key_in, set cnt=1, go to EXPAND.
- EXPAND: key_ready=0, busy=1.
  - Each cycle: rk[cnt] = f(rk[cnt-1], Rcon[cnt]); cnt++.
  - f = standard FIPS-197 schedule: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,0,0,0}, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - When cnt==NR, write the final key and go to READY.
- READY: keys_valid=1, busy=0, key_ready=1. On key_valid: rk[0]=key_in, keys_valid drops to 0 on the next edge, go to EXPAND.

Latency:
- Handshake edge = cycle 0. Expansion cycles 1..10. keys_valid=1 from cycle 11.
- Total is NR+1 cycles from accept to keys_valid.

Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (byte, left-aligned in w0).

Read port (one-cycle latency, registered):
- A request is sampled when rd_en=1. On the next cycle rd_valid=1, rd_key updated.
- ENCRYPT: returns rk[rd_round].
- DECRYPT: returns rk[NR - rd_round].
- rd_type INVALID or rd_round > NR: rd_valid=1, rd_key=0.
- rd_en=1 while keys_valid=0: rd_valid=1, rd_key=0. The block never stalls the reader.
- rd_en=0: rd_valid=0 next cycle; rd_key holds its last value.

Boundary and simultaneous-event rules:
- key_valid while busy: ignored, because key_ready=0. The source must hold the key.
- Read and new-key accept in the same READY cycle: the read returns the OLD key set, since the store is unchanged at that edge except rk[0], and the read mux samples pre-edge contents.
- Reset mid-EXPAND: all state cleared immediately. Partial keys are never exposed; keys_valid stays 0.
- cnt saturates at NR and never wraps.

Decomposition:
- Shared package (sysdef): job_t (INVALID, ENCRYPT, DECRYPT), AES_NR=10, Rcon lookup function, state enum key_fsm_t {IDLE, EXPAND, READY}.
- One sub-module: aes_sbox, a combinational 8-bit forward S-box. Four instances form SubWord.
- Key store is a flat register array rk[0:NR] of KW bits. A single next-key datapath is reused each cycle.

Test Plan:
1. Reset, then key 2b7e151628aed2a6abf7158809cf4f3c with key_valid for 1 cycle -> key_ready drops next cycle; keys_valid rises exactly 11 cycles after accept; busy=1 for cycles 1..10.
2. After test 1, read ENCRYPT rd_round=1 and rd_round=10 -> rd_key = a0fafe1788542cb123a339392a6c7605, then d014f9a8c9ee2589e13f0cc8b6630ca6; rd_valid one cycle after each rd_en.
3. DECRYPT rd_round=0 and rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, then 2b7e151628aed2a6abf7158809cf4f3c.
4. Key 000102030405060708090a0b0c0d0e0f, then ENCRYPT read round 10 -> 13111d7fe3944a17f307a78b4d2b30c5. Same-cycle read of round 10 on the accept edge -> returns the previous set's value.
5. rd_round=11, or rd_type=INVALID, or a read during EXPAND -> rd_valid=1, rd_key=0. key_valid pulsed mid-EXPAND -> ignored, final keys unchanged.
6. rst_n asserted at EXPAND cycle 5 -> keys_valid=0, busy=0, rd_key=0 immediately. A fresh key after release -> full 11-cycle expansion with correct results.

Source files
------------

// File: rtl/aes_key_expand_pkg.sv
// Shared definitions for the AES-128 key schedule: job types, FSM states,
// round count and the round-constant lookup.
package aes_key_expand_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_KW = 128;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } key_fsm_t;

  // Round constant for rounds 1..10, zero elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-load handshake and round-key read port of the key schedule.
interface aes_key_expand_if #(
  parameter int unsigned KW = 128
);
  import aes_key_expand_pkg::*;

  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] key_in;
  logic          keys_valid;
  logic          busy;
  logic          rd_en;
  logic [3:0]    rd_round;
  job_t          rd_type;
  logic          rd_valid;
  logic [KW-1:0] rd_key;

  modport master (
    output key_valid, key_in, rd_en, rd_round, rd_type,
    input  key_ready, keys_valid, busy, rd_valid, rd_key
  );

  modport slave (
    input  key_valid, key_in, rd_en, rd_round, rd_type,
    output key_ready, keys_valid, busy, rd_valid, rd_key
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SBOX[value];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry
// store, served through a registered read port in forward or reverse order.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned KW = AES_KW
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_expand_if.slave bus
);

  localparam logic [3:0] NR_L = 4'(NR);

  key_fsm_t      state, state_next;
  logic          load, expand;
  logic [3:0]    cnt, prev_idx;
  logic [KW-1:0] rk [0:NR];
  logic [KW-1:0] prev_key, next_key, rd_next, rd_key_q;
  logic          rd_valid_q;
  logic [31:0]   w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    expand     = 1'b0;
    unique case (state)
      IDLE, READY: begin
        if (bus.key_valid) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        expand = 1'b1;
        if (cnt == NR_L) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.key_ready  = (state != EXPAND);
  assign bus.busy       = (state == EXPAND);
  assign bus.keys_valid = (state == READY);

  // Single next-key datapath fed from the previously written store entry.
  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign prev_key = rk[prev_idx];
  assign {w0, w1, w2, w3} = prev_key;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .value (rot[8*g +: 8]),
      .subst (sub[8*g +: 8])
    );
  end

  assign n0       = w0 ^ sub ^ {rcon(cnt), 24'h000000};
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (load) begin
      rk[0] <= bus.key_in;
      cnt   <= 4'd1;
    end else if (expand) begin
      rk[cnt] <= next_key;
      if (cnt != NR_L) cnt <= cnt + 4'd1;
    end
  end

  // The read mux sees pre-edge store contents, so a read on a key-accept
  // edge still returns the old set.
  always_comb begin
    rd_next = '0;
    if (state == READY && bus.rd_round <= NR_L) begin
      case (bus.rd_type)
        ENCRYPT: rd_next = rk[bus.rd_round];
        DECRYPT: rd_next = rk[NR_L - bus.rd_round];
        default: rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_key_q <= rd_next;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_key   = rd_key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized self-checking bench for aes_key_expand against a word-level
// FIPS-197 key-schedule model with an arithmetically derived S-box.
module tb_aes_key_expand;
  import aes_key_expand_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_expand_if #(.KW(128)) bus_if ();

  aes_key_expand #(.NR(10), .KW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;
  logic [7:0]   sb_ref [256];
  logic [127:0] mk [11];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] expect_read(input int unsigned r, input job_t t);
    if (r > 10) return '0;
    if (t == ENCRYPT) return mk[r];
    if (t == DECRYPT) return mk[10 - r];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [127:0] key);
    bus_if.key_valid = 1'b1;
    bus_if.key_in    = key;
    tick();
    bus_if.key_valid = 1'b0;
    check("key_ready_after_accept", bus_if.key_ready, 1'b0);
    check("busy_cycle1", bus_if.busy, 1'b1);
  endtask

  // Runs expansion cycles 2..10 and the READY transition; optionally pokes a
  // bogus key and a read into the middle of the expansion.
  task automatic finish_expand(input logic [127:0] key, input bit disturb);
    for (int c = 2; c <= 10; c++) begin
      if (disturb && c == 4) begin
        bus_if.key_valid = 1'b1;
        bus_if.key_in    = ~key;
      end
      if (disturb && c == 6) begin
        bus_if.rd_en    = 1'b1;
        bus_if.rd_round = 4'd2;
        bus_if.rd_type  = ENCRYPT;
      end
      tick();
      bus_if.key_valid = 1'b0;
      if (disturb && c == 6) begin
        bus_if.rd_en = 1'b0;
        check("read_during_expand_valid", bus_if.rd_valid, 1'b1);
        check("read_during_expand_key", bus_if.rd_key, '0);
      end
      check("busy_during_expand", bus_if.busy, 1'b1);
      check("keys_valid_low_during_expand", bus_if.keys_valid, 1'b0);
    end
    tick();
    check("keys_valid_after_expand", bus_if.keys_valid, 1'b1);
    check("busy_after_expand", bus_if.busy, 1'b0);
    check("key_ready_in_ready", bus_if.key_ready, 1'b1);
    model_expand(key);
  endtask

  task automatic do_read(input logic [3:0] r, input job_t t, input logic [127:0] exp, input string tag);
    bus_if.rd_en    = 1'b1;
    bus_if.rd_round = r;
    bus_if.rd_type  = t;
    tick();
    bus_if.rd_en = 1'b0;
    check({tag, "_valid"}, bus_if.rd_valid, 1'b1);
    check(tag, bus_if.rd_key, exp);
  endtask

  task automatic random_reads(input int unsigned n);
    logic [3:0] r;
    job_t       t;
    for (int unsigned i = 0; i < n; i++) begin
      r = 4'($urandom_range(0, 12));
      case ($urandom_range(0, 2))
        0:       t = INVALID;
        1:       t = ENCRYPT;
        default: t = DECRYPT;
      endcase
      do_read(r, t, expect_read(r, t), "random_read");
    end
  endtask

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] key, old10;

  initial begin
    build_sbox();
    rst_n            = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.key_in    = '0;
    bus_if.rd_en     = 1'b0;
    bus_if.rd_round  = 4'd0;
    bus_if.rd_type   = INVALID;
    repeat (3) @(posedge clk);
    #1;
    check("reset_keys_valid", bus_if.keys_valid, 1'b0);
    check("reset_busy", bus_if.busy, 1'b0);
    check("reset_rd_valid", bus_if.rd_valid, 1'b0);
    check("reset_rd_key", bus_if.rd_key, '0);
    rst_n = 1'b1;
    tick();
    check("key_ready_after_reset", bus_if.key_ready, 1'b1);

    start_load(K1);
    finish_expand(K1, 1'b0);
    do_read(4'd1, ENCRYPT, 128'ha0fafe1788542cb123a339392a6c7605, "enc_r1_kat");
    do_read(4'd10, ENCRYPT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "enc_r10_kat");
    tick();
    check("idle_rd_valid_low", bus_if.rd_valid, 1'b0);
    check("idle_rd_key_hold", bus_if.rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_read(4'd0, DECRYPT, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "dec_r0_kat");
    do_read(4'd10, DECRYPT, K1, "dec_r10_kat");
    for (int r = 0; r <= 10; r++) do_read(4'(r), ENCRYPT, mk[r], "enc_sweep");

    // Read on the same edge that accepts a new key sees the old set.
    old10           = mk[10];
    bus_if.rd_en    = 1'b1;
    bus_if.rd_round = 4'd10;
    bus_if.rd_type  = ENCRYPT;
    start_load(K2);
    bus_if.rd_en = 1'b0;
    check("accept_edge_read_valid", bus_if.rd_valid, 1'b1);
    check("accept_edge_read_old", bus_if.rd_key, old10);
    finish_expand(K2, 1'b0);
    do_read(4'd10, ENCRYPT, 128'h13111d7fe3944a17f307a78b4d2b30c5, "enc_r10_kat2");

    do_read(4'd11, ENCRYPT, '0, "round_11");
    do_read(4'd15, DECRYPT, '0, "round_15_dec");
    do_read(4'd3, INVALID, '0, "invalid_type");

    key = {$urandom, $urandom, $urandom, $urandom};
    start_load(key);
    finish_expand(key, 1'b1);
    for (int r = 0; r <= 10; r++) do_read(4'(r), DECRYPT, mk[10 - r], "dec_sweep_after_disturb");

    repeat (4) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      start_load(key);
      finish_expand(key, 1'($urandom_range(0, 1)));
      random_reads(12);
    end

    // Reset mid-expansion.
    do_read(4'd5, ENCRYPT, mk[5], "pre_reset_read");
    key = {$urandom, $urandom, $urandom, $urandom};
    start_load(key);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_keys_valid", bus_if.keys_valid, 1'b0);
    check("midreset_busy", bus_if.busy, 1'b0);
    check("midreset_rd_key", bus_if.rd_key, '0);
    check("midreset_rd_valid", bus_if.rd_valid, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check("post_reset_keys_valid", bus_if.keys_valid, 1'b0);
    check("post_reset_key_ready", bus_if.key_ready, 1'b1);
    do_read(4'd0, ENCRYPT, '0, "post_reset_read");
    start_load(key);
    finish_expand(key, 1'b0);
    for (int r = 0; r <= 10; r++) do_read(4'(r), ENCRYPT, mk[r], "enc_sweep_after_reset");
    random_reads(16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
